// File: rtl/weight_load_sequencer.sv
// rtl/weight_load_sequencer.sv - paired-port weight BRAM fetch sequencer, one kernel at a time
// Optional busy-cycle counter output perf_cycles is built when LOAD_SEQ_PERF_EN is defined.
module weight_load_sequencer #(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int KERNEL_CNT_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [4:0]                    kernel_size,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] base_addr,
  input  logic [KERNEL_CNT_WIDTH-1:0]   kernel_num,
  input  logic                          stall,
  output logic                          bram_en_a,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_a,
  output logic                          bram_en_b,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_b,
  output logic                          data_valid,
  output logic                          data_len,
  output logic                          load_weight,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
`ifdef LOAD_SEQ_PERF_EN
  ,output logic [15:0]                  perf_cycles
`endif
);

  localparam int AW  = BRAM_ADDRESS_WIDTH;
  localparam int KW  = KERNEL_CNT_WIDTH;
  localparam int KW1 = KERNEL_CNT_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LAST,
    S_LOAD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    ksize_q, ksize_d;
  logic [AW-1:0] kern_base_q, kern_base_d;
  logic [KW-1:0] knum_q, knum_d;
  logic [KW-1:0] k_q, k_d;
  logic [2:0]    r_q, r_d;
  logic          load_weight_q, load_weight_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          cfg_err_q, cfg_err_d;
  logic          data_valid_q, data_valid_d;
  logic          data_len_q, data_len_d;
`ifdef LOAD_SEQ_PERF_EN
  logic [15:0]   perf_q, perf_d;
`endif

  logic [2:0]    ksize_dec;
  logic          issue_fire;
  logic          pair_b;

  always_comb begin
    ksize_dec = 3'd0;
    case (kernel_size)
      5'b00001: ksize_dec = 3'd1;
      5'b00010: ksize_dec = 3'd2;
      5'b00100: ksize_dec = 3'd3;
      5'b01000: ksize_dec = 3'd4;
      5'b10000: ksize_dec = 3'd5;
      default:  ksize_dec = 3'd0;
    endcase
  end

  // kern_base_q tracks base + k*K, so the read address is just kern_base_q + r.
  assign issue_fire  = (state_q == S_ISSUE) && !stall;
  assign pair_b      = (({1'b0, r_q} + 4'd1) < {1'b0, ksize_q});
  assign bram_en_a   = issue_fire;
  assign bram_en_b   = issue_fire && pair_b;
  assign bram_addr_a = issue_fire ? (kern_base_q + AW'(r_q)) : '0;
  assign bram_addr_b = (issue_fire && pair_b) ? (kern_base_q + AW'(r_q) + AW'(1)) : '0;

  always_comb begin
    state_d     = state_q;
    ksize_d     = ksize_q;
    kern_base_d = kern_base_q;
    knum_d      = knum_q;
    k_d         = k_q;
    r_d         = r_q;
    cfg_err_d   = cfg_err_q;
`ifdef LOAD_SEQ_PERF_EN
    perf_d      = perf_q;
    if (busy_q && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_err_d   = 1'b0;
          ksize_d     = ksize_dec;
          kern_base_d = base_addr;
          knum_d      = kernel_num;
          k_d         = '0;
          r_d         = 3'd0;
`ifdef LOAD_SEQ_PERF_EN
          perf_d      = 16'd0;
`endif
          if (ksize_dec == 3'd0) begin
            cfg_err_d = 1'b1;
            state_d   = S_DONE;
          end else if (kernel_num == '0) begin
            state_d   = S_DONE;
          end else begin
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          r_d = r_q + 3'd2;
          if (({1'b0, r_q} + 4'd2) >= {1'b0, ksize_q}) begin
            state_d = S_WAIT_LAST;
          end
        end
      end
      S_WAIT_LAST: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        k_d         = k_q + KW'(1);
        r_d         = 3'd0;
        kern_base_d = kern_base_q + AW'(ksize_q);
        if ((KW1'(k_q) + KW1'(1)) == KW1'(knum_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    load_weight_d = (state_d == S_LOAD);
    done_d        = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
    data_valid_d  = bram_en_a;
    data_len_d    = bram_en_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ksize_q       <= 3'd0;
      kern_base_q   <= '0;
      knum_q        <= '0;
      k_q           <= '0;
      r_q           <= 3'd0;
      load_weight_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      data_valid_q  <= 1'b0;
      data_len_q    <= 1'b0;
`ifdef LOAD_SEQ_PERF_EN
      perf_q        <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      ksize_q       <= ksize_d;
      kern_base_q   <= kern_base_d;
      knum_q        <= knum_d;
      k_q           <= k_d;
      r_q           <= r_d;
      load_weight_q <= load_weight_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      cfg_err_q     <= cfg_err_d;
      data_valid_q  <= data_valid_d;
      data_len_q    <= data_len_d;
`ifdef LOAD_SEQ_PERF_EN
      perf_q        <= perf_d;
`endif
    end
  end

  assign data_valid  = data_valid_q;
  assign data_len    = data_len_q;
  assign load_weight = load_weight_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
`ifdef LOAD_SEQ_PERF_EN
  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_weight_load_sequencer.sv
// tb/tb_weight_load_sequencer.sv - scoreboard bench for weight_load_sequencer
// Build with LOAD_SEQ_PERF_EN defined to also cover perf_cycles.
module tb_weight_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  kernel_size;
  logic [11:0] base_addr;
  logic [7:0]  kernel_num;
  logic        stall;
  logic        bram_en_a;
  logic [11:0] bram_addr_a;
  logic        bram_en_b;
  logic [11:0] bram_addr_b;
  logic        data_valid;
  logic        data_len;
  logic        load_weight;
  logic        busy;
  logic        done;
  logic        cfg_err;
`ifdef LOAD_SEQ_PERF_EN
  logic [15:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  weight_load_sequencer #(
    .BRAM_ADDRESS_WIDTH(12),
    .KERNEL_CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .kernel_size(kernel_size),
    .base_addr(base_addr),
    .kernel_num(kernel_num),
    .stall(stall),
    .bram_en_a(bram_en_a),
    .bram_addr_a(bram_addr_a),
    .bram_en_b(bram_en_b),
    .bram_addr_b(bram_addr_b),
    .data_valid(data_valid),
    .data_len(data_len),
    .load_weight(load_weight),
    .busy(busy),
    .done(done),
    .cfg_err(cfg_err)
`ifdef LOAD_SEQ_PERF_EN
    ,.perf_cycles(perf_cycles)
`endif
  );

  typedef struct packed {
    logic [11:0] a;
    logic        b_en;
    logic [11:0] b;
  } rd_t;

  rd_t rdq[$];
  int  lwq[$];
  int  dnq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  done_cnt = 0;
  int  busy_cnt = 0;
  logic dv_next = 1'b0;
  logic dl_next = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {bram_en_a, bram_en_b, bram_addr_a, bram_addr_b,
            data_valid, data_len, load_weight, busy, done, cfg_err};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected reads/pulses as the DUT produces them.
  always @(negedge clk) begin
    rd_t rec;
    if (dv_next || data_valid) begin
      check("data_valid", data_valid, dv_next);
      check("data_len", data_len, dl_next);
    end
    dv_next = 1'b0;
    dl_next = 1'b0;
    if (bram_en_a || bram_en_b) begin
      if (rdq.size() == 0) begin
        check("rd_unexpected", bram_en_a | bram_en_b, 0);
      end else begin
        rec = rdq.pop_front();
        check("en_a", bram_en_a, 1);
        check("addr_a", bram_addr_a, rec.a);
        check("en_b", bram_en_b, rec.b_en);
        if (rec.b_en) check("addr_b", bram_addr_b, rec.b);
        dv_next = 1'b1;
        dl_next = rec.b_en;
      end
    end
    if (rst) begin
      dv_next = 1'b0;
      dl_next = 1'b0;
    end
    if (load_weight) begin
      if (lwq.size() == 0) check("lw_unexpected", load_weight, 0);
      else check("lw_cycle", cyc - t0, lwq.pop_front());
    end
    if (done) begin
      done_cnt++;
      if (dnq.size() == 0) check("done_unexpected", done, 0);
      else check("done_cycle", cyc - t0, dnq.pop_front());
    end
    if (busy) busy_cnt++;
  end

  task automatic push_model(input int kk, input logic [11:0] base, input int knum, input int stall_at);
    int  t;
    int  p;
    int  pe;
    rd_t rec;
    t = 1;
    if (kk == 0 || knum == 0) begin
      dnq.push_back(1);
      return;
    end
    p = (kk + 1) / 2;
    for (int n = 0; n < knum; n++) begin
      for (int r = 0; r < kk; r += 2) begin
        rec.a    = base + 12'(n * kk + r);
        rec.b_en = (r + 1 < kk);
        rec.b    = rec.b_en ? rec.a + 12'd1 : 12'd0;
        rdq.push_back(rec);
      end
      pe = (stall_at >= t && stall_at < t + p) ? p + 1 : p;
      lwq.push_back(t + pe + 1);
      t += pe + 2;
    end
    dnq.push_back(t);
  endtask

  task automatic run(input logic [4:0] ks, input int kk, input logic [11:0] base,
                     input logic [7:0] kn, input int stall_at, input int restart_at);
    int n0;
    push_model(kk, base, int'(kn), stall_at);
    @(posedge clk);
    #1;
    kernel_size = ks;
    base_addr   = base;
    kernel_num  = kn;
    start       = 1'b1;
    t0          = cyc;
    n0          = done_cnt;
    busy_cnt    = 0;
    for (int n = 1; n < 300 && done_cnt == n0; n++) begin
      @(posedge clk);
      #1;
      start = (n == restart_at);
      if (n == restart_at) base_addr = base + 12'h100;
      stall = (n == stall_at);
    end
    start = 1'b0;
    stall = 1'b0;
    if (done_cnt == n0) check("done_timeout", done_cnt, n0 + 1);
    @(negedge clk);
    check("rd_left", rdq.size(), 0);
    check("lw_left", lwq.size(), 0);
    check("done_left", dnq.size(), 0);
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    kernel_size = 5'b0;
    base_addr = 12'h0;
    kernel_num = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);

    run(5'b00100, 3, 12'h010, 8'd2, -1, -1);
    check("busy_cycles", busy_cnt, 9);
`ifdef LOAD_SEQ_PERF_EN
    check("perf_cycles", perf_cycles, 9);
`endif

    run(5'b00001, 1, 12'hFFF, 8'd2, -1, -1);
    run(5'b10000, 5, 12'h020, 8'd1, 2, -1);

    run(5'b00110, 0, 12'h040, 8'd1, -1, -1);
    check("cfg_err_set", cfg_err, 1);

    run(5'b00010, 2, 12'h200, 8'd1, -1, 1);
    check("cfg_err_clear", cfg_err, 0);

    run(5'b00100, 3, 12'h050, 8'd0, -1, -1);

    // Reset in the middle of a K=4 kernel: two reads land, then everything stops.
    rdq.push_back('{a: 12'h100, b_en: 1'b1, b: 12'h101});
    rdq.push_back('{a: 12'h102, b_en: 1'b1, b: 12'h103});
    @(posedge clk);
    #1;
    kernel_size = 5'b01000;
    base_addr   = 12'h100;
    kernel_num  = 8'd3;
    start       = 1'b1;
    t0          = cyc;
    n0          = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", all_outs(), 0);
    repeat (6) @(negedge clk);
    check("rst_no_done", done_cnt, n0);
    check("rst_rd_left", rdq.size(), 0);
    check("rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
